// File: rtl/road_pkg.sv
// road_pkg: shared types and constants for the road renderer.
//   LEVEL_DIV / level_div() : level (0..3) to scroll divider {6,5,4,3}
//   *_RGB                   : default 12-bit output colours
//   pix_class_t             : stage-1 pixel class {GRASS, ASPHALT, EDGE, DASH}
// Optional feature macro used by importers: ROAD_SCROLL_ACCEL_EN.
package road_pkg;

   localparam int unsigned DIV_W = 3;
   localparam int unsigned RGB_W = 12;

   // Ramp start value for the effective divider (slowest speed).
   localparam logic [DIV_W-1:0] DIV_RESET = 3'd6;

   localparam logic [DIV_W-1:0] LEVEL_DIV [4] = '{3'd6, 3'd5, 3'd4, 3'd3};

   localparam logic [RGB_W-1:0] GRASS_RGB   = 12'h0A0;
   localparam logic [RGB_W-1:0] ASPHALT_RGB = 12'h444;
   localparam logic [RGB_W-1:0] WHITE_RGB   = 12'hFFF;

   // GRASS encodes as zero so a cleared pipeline register reads as grass.
   typedef enum logic [1:0] {
      GRASS   = 2'd0,
      ASPHALT = 2'd1,
      EDGE    = 2'd2,
      DASH    = 2'd3
   } pix_class_t;

   function automatic logic [DIV_W-1:0] level_div(input logic [1:0] level);
      return LEVEL_DIV[level];
   endfunction

endpackage

// File: rtl/road_scroll_timer.sv
// road_scroll_timer: base tick prescaler, level divider and scroll offset
// accumulator for the road renderer.
//   clk, reset_n : system clock, asynchronous active-low reset
//   level        : game level 0..3, selects the divider
//   pause        : holds both counters and suppresses scroll ticks
//   next_offset  : scroll offset accumulated so far (registered)
// ROAD_SCROLL_ACCEL_EN: when defined, the divider ramps one step per scroll
// tick toward the level target instead of following level directly.
module road_scroll_timer
   import road_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 100_000_000,
   parameter int unsigned TICK_HZ     = 500,
   parameter int unsigned PERIOD_LOG2 = 6,
   parameter int unsigned STEP        = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [1:0]             level,
   input  logic                   pause,
   output logic [PERIOD_LOG2-1:0] next_offset
);

   localparam int unsigned BASE_N = CLK_HZ / TICK_HZ;
   localparam int unsigned BASE_W = (BASE_N > 1) ? $clog2(BASE_N) : 1;
   localparam logic [BASE_W-1:0] BASE_MAX = BASE_W'(BASE_N - 1);

   logic [BASE_W-1:0] base_cnt;
   logic [DIV_W-1:0]  sub_cnt;
   logic [DIV_W-1:0]  div;
   logic              base_tick;
   logic              scroll_tick;

   assign base_tick   = !pause && (base_cnt == BASE_MAX);
   // >= so that a divider that drops below sub_cnt still wraps next tick
   assign scroll_tick = base_tick && (sub_cnt >= div);

`ifdef ROAD_SCROLL_ACCEL_EN
   logic [DIV_W-1:0] eff_div;
   logic [DIV_W-1:0] target_div;

   assign target_div = level_div(level);
   assign div        = eff_div;

   // Effective divider walks toward the level target one step per scroll tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         eff_div <= DIV_RESET;
      end else if (scroll_tick) begin
         if (eff_div > target_div)
            eff_div <= eff_div - DIV_W'(1);
         else if (eff_div < target_div)
            eff_div <= eff_div + DIV_W'(1);
      end
   end
`else
   assign div = level_div(level);
`endif

   // Base prescaler and level divider; both freeze while paused.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_cnt <= '0;
         sub_cnt  <= '0;
      end else if (!pause) begin
         base_cnt <= base_tick ? '0 : base_cnt + BASE_W'(1);
         if (base_tick)
            sub_cnt <= scroll_tick ? '0 : sub_cnt + DIV_W'(1);
      end
   end

   // Offset wraps naturally modulo the dash period.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         next_offset <= '0;
      else if (scroll_tick)
         next_offset <= next_offset + PERIOD_LOG2'(STEP);
   end

endmodule

// File: rtl/road_scroller.sv
// road_scroller: background road renderer with scrolling dashed dividers.
//   clk, reset_n     : system clock, asynchronous active-low reset
//   pix_row, pix_col : pixel position from the display timing generator
//   level            : game level 0..3 (scroll speed)
//   pause            : freezes scrolling while high
//   road_out         : RGB of the pixel presented two cycles earlier
//   scroll_offset    : offset in use for the current frame
// ROAD_SCROLL_ACCEL_EN: enables the smooth speed ramp in road_scroll_timer.
module road_scroller
   import road_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 100_000_000,
   parameter int unsigned TICK_HZ     = 500,
   parameter int unsigned NUM_LANES   = 3,
   parameter int unsigned ROAD_LEFT   = 192,
   parameter int unsigned LANE_W      = 128,
   parameter int unsigned LINE_W      = 4,
   parameter int unsigned DASH_LEN    = 32,
   parameter int unsigned PERIOD_LOG2 = 6,
   parameter int unsigned STEP        = 8,
   parameter logic [11:0] GRASS       = GRASS_RGB,
   parameter logic [11:0] ASPHALT     = ASPHALT_RGB,
   parameter logic [11:0] WHITE       = WHITE_RGB
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [9:0]             pix_row,
   input  logic [9:0]             pix_col,
   input  logic [1:0]             level,
   input  logic                   pause,
   output logic [11:0]            road_out,
   output logic [PERIOD_LOG2-1:0] scroll_offset
);

   localparam int unsigned ROAD_END  = ROAD_LEFT + NUM_LANES * LANE_W;
   localparam int unsigned HALF_LINE = LINE_W / 2;

   logic [PERIOD_LOG2-1:0] next_offset;
   logic [PERIOD_LOG2-1:0] phase;
   logic [31:0]            col;
   logic                   on_divider;
   pix_class_t             cls_d;
   pix_class_t             cls_q;

   road_scroll_timer #(
      .CLK_HZ      (CLK_HZ),
      .TICK_HZ     (TICK_HZ),
      .PERIOD_LOG2 (PERIOD_LOG2),
      .STEP        (STEP)
   ) u_timer (
      .clk         (clk),
      .reset_n     (reset_n),
      .level       (level),
      .pause       (pause),
      .next_offset (next_offset)
   );

   // Offset only changes at the first pixel of a frame, so a frame never tears.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         scroll_offset <= '0;
      else if (pix_row == '0 && pix_col == '0)
         scroll_offset <= next_offset;
   end

   assign col   = 32'(pix_col);
   assign phase = PERIOD_LOG2'(pix_row) - scroll_offset;

   // Stage 1 classification; HALF_LINE is added on the column side to avoid underflow.
   always_comb begin
      on_divider = 1'b0;
      cls_d      = road_pkg::ASPHALT;
      for (int unsigned k = 1; k < NUM_LANES; k++) begin
         if ((col + HALF_LINE >= ROAD_LEFT + k * LANE_W) &&
             (col + HALF_LINE <  ROAD_LEFT + k * LANE_W + LINE_W))
            on_divider = 1'b1;
      end
      if (col < ROAD_LEFT || col >= ROAD_END)
         cls_d = road_pkg::GRASS;
      else if (col < ROAD_LEFT + LINE_W || col >= ROAD_END - LINE_W)
         cls_d = road_pkg::EDGE;
      else if (on_divider && (32'(phase) < DASH_LEN))
         cls_d = road_pkg::DASH;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cls_q <= road_pkg::GRASS;
      else
         cls_q <= cls_d;
   end

   // Stage 2 colour mux.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         road_out <= '0;
      end else begin
         case (cls_q)
            road_pkg::GRASS:   road_out <= GRASS;
            road_pkg::ASPHALT: road_out <= ASPHALT;
            default:           road_out <= WHITE;
         endcase
      end
   end

endmodule

// File: tb/tb_road_scroller.sv
// tb_road_scroller: self-checking bench for road_scroller with a fast tick
// (CLK_HZ=1000, TICK_HZ=100 -> base tick every 10 clocks). A behavioural
// model predicts road_out, scroll_offset and next_offset every cycle;
// directed steps pin the model with hand-computed values, then randomized
// pixels, levels, pauses and resets run against it.
// Honors ROAD_SCROLL_ACCEL_EN to match the design build.
module tb_road_scroller;

   localparam int BASE_N    = 10;
   localparam int PERIOD    = 64;
   localparam int STEP      = 8;
   localparam int NUM_LANES = 3;
   localparam int ROAD_LEFT = 192;
   localparam int LANE_W    = 128;
   localparam int LINE_W    = 4;
   localparam int DASH_LEN  = 32;
   localparam logic [11:0] C_G = 12'h0A0;
   localparam logic [11:0] C_A = 12'h444;
   localparam logic [11:0] C_W = 12'hFFF;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic [9:0]  pix_row = 10'd0;
   logic [9:0]  pix_col = 10'd0;
   logic [1:0]  level   = 2'd0;
   logic        pause   = 1'b0;
   logic [11:0] road_out;
   logic [5:0]  scroll_offset;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   road_scroller #(
      .CLK_HZ(1000), .TICK_HZ(100), .NUM_LANES(NUM_LANES), .ROAD_LEFT(ROAD_LEFT),
      .LANE_W(LANE_W), .LINE_W(LINE_W), .DASH_LEN(DASH_LEN), .PERIOD_LOG2(6),
      .STEP(STEP), .GRASS(C_G), .ASPHALT(C_A), .WHITE(C_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .pix_row(pix_row), .pix_col(pix_col),
      .level(level), .pause(pause), .road_out(road_out), .scroll_offset(scroll_offset)
   );

   always @(posedge clk or negedge reset_n)
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      int          act;    // unpaused clocks since reset
      int          ticks;  // base ticks since the last scroll tick
      int          eff;    // ramped divider (accel build)
      int          nxt;    // next_offset
      int          soff;   // scroll_offset
      int          age;    // clocks since reset release, saturating at 2
      logic [11:0] s1;     // colour decided for the previous pixel
      logic [11:0] out;    // road_out
   } mstate_t;

   mstate_t ms;

   function automatic logic [11:0] road_rgb(input int row, input int col, input int off);
      int road_end, phase, d;
      road_end = ROAD_LEFT + NUM_LANES * LANE_W;
      phase    = (((row - off) % PERIOD) + PERIOD) % PERIOD;
      if (col < ROAD_LEFT || col >= road_end) return C_G;
      if (col < ROAD_LEFT + LINE_W || col >= road_end - LINE_W) return C_W;
      d = col - ROAD_LEFT + LINE_W / 2;
      if ((d / LANE_W) >= 1 && (d / LANE_W) <= NUM_LANES - 1 &&
          (d % LANE_W) < LINE_W && phase < DASH_LEN) return C_W;
      return C_A;
   endfunction

   function automatic int div_of(input int lvl);
      return 6 - lvl;
   endfunction

   function automatic mstate_t model_reset();
      mstate_t r;
      r = '0;
      r.eff = 6;
      return r;
   endfunction

   function automatic mstate_t model_step(input mstate_t s, input int row, input int col,
                                          input int lvl, input bit pz);
      mstate_t n;
      int      div;
      bit      stick;
      n     = s;
      stick = 1'b0;
      n.out = s.s1;
      n.s1  = road_rgb(row, col, s.soff);
      if (s.age < 2) n.age = s.age + 1;
      if (row == 0 && col == 0) n.soff = s.nxt;
`ifdef ROAD_SCROLL_ACCEL_EN
      div = s.eff;
`else
      div = div_of(lvl);
`endif
      if (!pz) begin
         n.act = s.act + 1;
         if (n.act % BASE_N == 0) begin
            if (s.ticks >= div) begin n.ticks = 0; stick = 1'b1; end
            else n.ticks = s.ticks + 1;
         end
      end
      if (stick) begin
         n.nxt = (s.nxt + STEP) % PERIOD;
`ifdef ROAD_SCROLL_ACCEL_EN
         if (s.eff > div_of(lvl)) n.eff = s.eff - 1;
         else if (s.eff < div_of(lvl)) n.eff = s.eff + 1;
`endif
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset_n)
      if (!reset_n) ms <= model_reset();
      else ms <= model_step(ms, int'(pix_row), int'(pix_col), int'(level), pause);

   // ---------------- checking ----------------
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp, cyc);
      end
   endtask

   initial begin : cmp
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            chk("reset road_out", int'(road_out), 0);
            chk("reset scroll_offset", int'(scroll_offset), 0);
         end else begin
            chk("scroll_offset", int'(scroll_offset), ms.soff);
            chk("next_offset", int'(dut.u_timer.next_offset), ms.nxt);
            if (ms.age >= 2) chk("road_out", int'(road_out), int'(ms.out));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_cyc(input int k);
      int guard;
      guard = 0;
      while (cyc < k && guard < 50000) begin step(1); guard++; end
      if (cyc != k) chk("wait_cyc", cyc, k);
   endtask

   task automatic chk_next(input string name, input int exp);
      chk({name, " dut"}, int'(dut.u_timer.next_offset), exp);
      chk({name, " model"}, ms.nxt, exp);
   endtask

   task automatic chk_pix(input int row, input int col, input logic [11:0] exp, input string name);
      pix_row = 10'(row);
      pix_col = 10'(col);
      step(2);
      chk(name, int'(road_out), int'(exp));
   endtask

   // pixel table at scroll_offset 0: row, col, colour
   int          t0_row [20] = '{5, 40, 10, 10, 10, 10, 10, 10, 10, 10,
                                10, 10, 10, 5, 5, 5, 5, 31, 32, 0};
   int          t0_col [20] = '{320, 320, 100, 193, 250, 191, 192, 195, 196, 571,
                                572, 575, 576, 317, 318, 321, 322, 446, 446, 449};
   logic [11:0] t0_exp [20] = '{C_W, C_A, C_G, C_W, C_A, C_G, C_W, C_W, C_A, C_A,
                                C_W, C_W, C_G, C_A, C_W, C_W, C_A, C_W, C_A, C_W};
   // pixel table at scroll_offset 16, col 320
   int          t1_row [6]  = '{5, 20, 15, 16, 47, 48};
   logic [11:0] t1_exp [6]  = '{C_A, C_W, C_A, C_W, C_W, C_A};

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int r;
      reset_n = 1'b0; level = 2'd0; pause = 1'b0; pix_row = 10'd10; pix_col = 10'd100;
      step(3);
      chk("reset road_out lit", int'(road_out), 0);
      chk("reset scroll_offset lit", int'(scroll_offset), 0);
      chk_next("reset next_offset", 0);
      reset_n = 1'b1;

      for (int i = 0; i < 20; i++) chk_pix(t0_row[i], t0_col[i], t0_exp[i], "pix off0");

      wait_cyc(69);
      chk_next("before first tick", 0);
      step(1);
      chk_next("first tick cyc70", 8);

      wait_cyc(141);
      chk_next("second tick", 16);
      chk("no latch mid frame", int'(scroll_offset), 0);
      pix_row = 10'd0; pix_col = 10'd0;
      step(1);
      chk("latch 16", int'(scroll_offset), 16);
      for (int i = 0; i < 6; i++) chk_pix(t1_row[i], 320, t1_exp[i], "pix off16");

      wait_cyc(559);
      chk_next("seventh tick", 56);
      chk("offset held to frame", int'(scroll_offset), 16);
      step(1);
      chk_next("wrap after 8 ticks", 0);
      pix_row = 10'd0; pix_col = 10'd0;
      step(1);
      chk("latch wrapped", int'(scroll_offset), 0);
      pix_row = 10'd10; pix_col = 10'd10;

      wait_cyc(585);
      pause = 1'b1;
      step(500);
      chk_next("held by pause", 0);
      pause = 1'b0;
      wait_cyc(1129);
      chk_next("resume before tick", 0);
      step(1);
      chk_next("resume tick", 8);

      wait_cyc(1180);
      level = 2'd3;
`ifdef ROAD_SCROLL_ACCEL_EN
      wait_cyc(1190); chk_next("ramp no tick at 1190", 8);
      wait_cyc(1200); chk_next("ramp tick div6", 16);
      wait_cyc(1259); chk_next("ramp before div5", 16);
      wait_cyc(1260); chk_next("ramp tick div5", 24);
      wait_cyc(1310); chk_next("ramp tick div4", 32);
      wait_cyc(1350); chk_next("ramp tick div3", 40);
      wait_cyc(1390); chk_next("ramp steady div3", 48);
`else
      wait_cyc(1189); chk_next("level3 before tick", 8);
      step(1);        chk_next("level3 next base tick", 16);
      wait_cyc(1229); chk_next("level3 before 2nd", 16);
      wait_cyc(1230); chk_next("level3 period", 24);
      wait_cyc(1270); chk_next("level3 period 2", 32);
`endif

      pix_row = 10'd200; pix_col = 10'd300;
      step(3);
      reset_n = 1'b0;
      #1;
      chk("async clear road_out", int'(road_out), 0);
      chk("async clear scroll_offset", int'(scroll_offset), 0);
      chk_next("async clear next_offset", 0);
      step(2);
      reset_n = 1'b1;
      chk_pix(10, 100, C_G, "valid after release");

      for (int i = 0; i < 20000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            pix_row = 10'd0; pix_col = 10'd0;
         end else begin
            pix_row = 10'($urandom_range(0, 80));
            pix_col = 10'($urandom_range(150, 600));
            if ($urandom_range(0, 3) == 0) pix_col = 10'($urandom);
         end
         if ($urandom_range(0, 299) == 0) level = 2'($urandom);
         if ($urandom_range(0, 199) == 0) pause = ~pause;
         if ($urandom_range(0, 4999) == 0) begin
            reset_n = 1'b0;
            step(2);
            reset_n = 1'b1;
         end
         step(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
